timer_seq_ctrl: RTL and testbench
=================================

Name: timer_seq_ctrl

Overview:
Programmable sequencer that drives a WIDTH-bit synchronous up-counter. It runs the counter in one-shot or periodic mode over a configured period. It generates terminal-count tick and done pulses and supports start, stop and pause control. It sits between software-style control strobes and the T-flip-flop counter datapath, so the counter is only ever enabled, cleared and wrapped under controller supervision.

Parameters:
WIDTH, 4, counter and period width in bits; legal range 2..16.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
cfg_load  input  1  latch period and mode into config registers (accepted in IDLE only)
period  input  WIDTH  terminal count P; tick interval is P+1 cycles
mode  input  1  0 = one-shot, 1 = periodic; sampled with cfg_load
start  input  1  begin counting (accepted in IDLE only)
stop  input  1  abort: return to IDLE and clear the counter
pause  input  1  level-sensitive hold while running
busy  output  1  high in RUN or PAUSE
cnt  output  WIDTH  current counter value
tick  output  1  one-cycle pulse on terminal-count wrap
done  output  1  one-cycle pulse when a one-shot run completes
err  output  1  one-cycle pulse on an illegal request

Behaviour:
- Reset (async, any time, including mid-run): state=IDLE, cnt=0, period_q=0, mode_q=0. busy, tick, done and err are all 0. All outputs are registered.
- States, 2-bit: IDLE, RUN, PAUSE.
- IDLE: counter cleared and disabled.
  - cfg_load: period_q<=period, mode_q<=mode.
  - start with period_q!=0: go to RUN, cnt stays 0.
  - start with period_q==0: stay IDLE, err=1 for one cycle.
  - cfg_load and start in the same cycle: the start uses the OLD period_q.
- RUN: counter enabled, cnt increments by 1 per cycle.
  - Terminal edge (cnt==period_q): cnt<=0 and tick<=1.
  - One-shot terminal: also done<=1 and go to IDLE.
  - Periodic terminal: stay in RUN.
- PAUSE: counter enable low, cnt holds. pause deasserted: return to RUN next edge, counting resumes from the held value.
- Latency: start sampled at edge k gives busy=1, cnt=0 after k. cnt=P after edge k+P. tick (and done for one-shot) high after edge k+P+1, i.e. P+1 cycles after start. Periodic ticks then follow every P+1 cycles.
- Priority per edge: stop > terminal > pause.
  - stop in RUN/PAUSE: go to IDLE, cnt<=0, no tick or done, even on the terminal cycle.
  - stop in IDLE: no effect.
- Terminal and pause together: wrap occurs and tick fires. Periodic goes to PAUSE with cnt=0. One-shot goes to IDLE with done=1.
- Requests while RUN or PAUSE:
  - start: ignored, no err.
  - cfg_load: ignored, err=1; period_q and mode_q unchanged.
- period_q = 2^WIDTH-1: cnt wraps from all-ones to 0 naturally, tick still asserted.
- tick, done and err are never held for more than one cycle.

Decomposition:
- Shared package timer_seq_pkg: state encodings ST_IDLE=2'b00, ST_RUN=2'b01, ST_PAUSE=2'b10; mode constants MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1.
- One sub-module, tff_up_counter: WIDTH-bit T-flip-flop ripple-enable synchronous counter with en and synchronous clr inputs and async active-high reset.
  - clr has priority over en.
  - The controller drives en = (state==RUN) and clr = terminal | stop | (state==IDLE).

Test Plan:
- Reset mid-run: cfg P=5 periodic, start, assert reset at cnt=3 -> all outputs 0 and state IDLE immediately; reset release -> stays IDLE, cnt=0.
- One-shot: cfg_load P=3 mode=0, start at edge k -> cnt 0,1,2,3 after edges k..k+3; tick=done=1 after k+4 only; busy=0 after k+4.
- Periodic: P=2 mode=1, start -> tick pulses every 3 cycles; cnt sequence 0,1,2,0,1,2; done never asserted.
- Pause/resume: P=6 periodic, pause held 4 cycles at cnt=2 -> cnt stays 2, busy=1; release -> cnt=3 next edge, tick shifted by 4 cycles.
- Simultaneous events: stop on the terminal cycle -> IDLE, cnt=0, no tick. Pause on the terminal cycle (periodic) -> tick=1, PAUSE, cnt=0.
- Illegal requests:
  - start with period_q=0 -> err pulse, stays IDLE.
  - cfg_load during RUN -> err pulse, period_q unchanged.
  - WIDTH=4, P=15 periodic -> wrap 15->0 with tick.

Source files
------------

// File: rtl/timer_seq_pkg.sv
// Shared encodings for the timer sequencer and its counter datapath.
package timer_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/tff_up_counter.sv
// WIDTH-bit synchronous up-counter built from toggle flip-flops with a
// ripple-AND enable chain. Synchronous clear wins over enable.
module tff_up_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] t;

  // Bit i toggles when enabled and all lower bits are one.
  always_comb begin
    t[0] = en;
    for (int i = 1; i < int'(WIDTH); i++) begin
      t[i] = t[i-1] & q[i-1];
    end
  end

  // Toggle register with async reset and sync clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/timer_seq_ctrl.sv
// Sequencer supervising a T-flip-flop up-counter: one-shot or periodic runs
// over a configured period, with start/stop/pause control and
// tick/done/err pulses. All outputs are registered.
module timer_seq_ctrl
  import timer_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] period,
  input  logic             mode,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  output logic             busy,
  output logic [WIDTH-1:0] cnt,
  output logic             tick,
  output logic             done,
  output logic             err
);

  state_t           state_q;
  logic [WIDTH-1:0] period_q;
  logic             mode_q;
  logic             busy_q;
  logic             tick_q;
  logic             done_q;
  logic             err_q;

  logic terminal;
  logic cnt_en;
  logic cnt_clr;

  // Counter supervision: count only in RUN, hold it cleared in IDLE and on
  // wrap or abort.
  always_comb begin
    terminal = (state_q == ST_RUN) && (cnt == period_q);
    cnt_en   = (state_q == ST_RUN);
    cnt_clr  = terminal | stop | (state_q == ST_IDLE);
  end

  tff_up_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .q     (cnt)
  );

  // Control FSM with registered pulse outputs; priority stop > terminal > pause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      mode_q   <= MODE_ONESHOT;
      busy_q   <= 1'b0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_load) begin
            period_q <= period;
            mode_q   <= mode;
          end
          // A simultaneous cfg_load does not affect this check: old period_q.
          if (start) begin
            if (period_q != '0) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (cfg_load) err_q <= 1'b1;
          if (stop) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (terminal) begin
            tick_q <= 1'b1;
            if (mode_q == MODE_ONESHOT) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else if (pause) begin
              state_q <= ST_PAUSE;
            end
          end else if (pause) begin
            state_q <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (cfg_load) err_q <= 1'b1;
          if (stop) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (!pause) begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign tick = tick_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Directed self-checking bench for timer_seq_ctrl (WIDTH=4).
module tb_timer_seq_ctrl;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             cfg_load;
  logic [WIDTH-1:0] period;
  logic             mode;
  logic             start;
  logic             stop;
  logic             pause;
  logic             busy;
  logic [WIDTH-1:0] cnt;
  logic             tick;
  logic             done;
  logic             err;

  int n_tests = 0;
  int n_fail  = 0;

  timer_seq_ctrl #(
    .WIDTH (WIDTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_load (cfg_load),
    .period   (period),
    .mode     (mode),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .busy     (busy),
    .cnt      (cnt),
    .tick     (tick),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [WIDTH-1:0] p, input logic m);
    cfg_load = 1'b1;
    period   = p;
    mode     = m;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic b, input logic [WIDTH-1:0] c,
                            input logic t, input logic d, input logic e);
    check({tag, ".busy"}, 32'(b), 32'(busy));
    check({tag, ".cnt"},  32'(cnt), 32'(c));
    check({tag, ".tick"}, 32'(tick), 32'(t));
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".err"},  32'(err), 32'(e));
  endtask

  // Expected per-edge values for the periodic P=2 run.
  logic [WIDTH-1:0] per_cnt [6] = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0};
  logic             per_tck [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    reset = 1'b1; cfg_load = 1'b0; period = '0; mode = 1'b0;
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    step();
    step();
    check_outs("reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    check_outs("post_reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // One-shot P=3.
    cfg(4'd3, 1'b0);
    do_start();
    check_outs("os_k", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    step(); check("os_k1.cnt", 32'(cnt), 32'd1);
    step(); check("os_k2.cnt", 32'(cnt), 32'd2);
    step(); check_outs("os_k3", 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    step(); check_outs("os_k4", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    step(); check_outs("os_k5", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Periodic P=2: tick every 3 cycles, no done.
    cfg(4'd2, 1'b1);
    do_start();
    check("per_k.cnt", 32'(cnt), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("per_%0d.cnt", i), 32'(cnt), 32'(per_cnt[i]));
      check($sformatf("per_%0d.tick", i), 32'(tick), 32'(per_tck[i]));
      check($sformatf("per_%0d.done", i), 32'(done), 32'd0);
    end
    do_stop();
    check_outs("per_stop", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Pause/resume, P=6 periodic; pause sampled on 4 edges.
    cfg(4'd6, 1'b1);
    do_start();
    step(); check("pz_k1.cnt", 32'(cnt), 32'd1);
    pause = 1'b1;
    step(); check_outs("pz_enter", 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("pz_hold%0d.cnt", i), 32'(cnt), 32'd2);
      check($sformatf("pz_hold%0d.busy", i), 32'(busy), 32'd1);
    end
    pause = 1'b0;
    step(); check("pz_resume.cnt", 32'(cnt), 32'd2);
    step(); check("pz_k7.cnt", 32'(cnt), 32'd3);
    step(); step(); step();
    check_outs("pz_k10", 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("pz_k11", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    do_stop();

    // Stop on the terminal cycle beats the wrap.
    cfg(4'd2, 1'b1);
    do_start();
    step(); step();
    check("st_term.cnt", 32'(cnt), 32'd2);
    do_stop();
    check_outs("st_term", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Pause on the terminal cycle: wrap + tick, then hold at 0.
    do_start();
    step(); step();
    pause = 1'b1;
    step(); check_outs("pz_term", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    step(); check_outs("pz_term_hold", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    pause = 1'b0;
    step(); check("pz_term_back.cnt", 32'(cnt), 32'd0);
    step(); check("pz_term_run.cnt", 32'(cnt), 32'd1);
    do_stop();

    // Start with period_q == 0.
    cfg(4'd0, 1'b0);
    do_start();
    check_outs("zero_start", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    step(); check("zero_start_clr.err", 32'(err), 32'd0);

    // cfg_load during RUN is rejected; P=3 one-shot still applies.
    cfg(4'd3, 1'b0);
    do_start();
    cfg_load = 1'b1; period = 4'd9; mode = 1'b1;
    step();
    cfg_load = 1'b0;
    check_outs("cfg_run", 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
    step(); check("cfg_run_k2.err", 32'(err), 32'd0);
    step(); check("cfg_run_k3.cnt", 32'(cnt), 32'd3);
    step(); check_outs("cfg_run_k4", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);

    // cfg_load and start together: start sees old period_q (3), loads 0.
    cfg_load = 1'b1; period = 4'd0; mode = 1'b1; start = 1'b1;
    step();
    cfg_load = 1'b0; start = 1'b0;
    check_outs("cfg_start", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    do_stop();
    do_start();
    check_outs("cfg_start_new0", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Full-range period 15, periodic: natural wrap with tick.
    cfg(4'd15, 1'b1);
    do_start();
    for (int i = 0; i < 15; i++) step();
    check_outs("p15_top", 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("p15_wrap", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    do_stop();

    // Reset mid-run at cnt=3.
    cfg(4'd5, 1'b1);
    do_start();
    step(); step(); step();
    check("rst_mid_pre.cnt", 32'(cnt), 32'd3);
    reset = 1'b1;
    #1;
    check_outs("rst_mid", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    step();
    check_outs("rst_mid_rel", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    do_start();
    check_outs("rst_mid_p0", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
